// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/sub with optional unsigned saturation,
// carried through a STAGES-deep valid/ready pipeline with bubble collapsing.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   operand beat handshake (a, b, op)
//   out_valid/out_ready result beat handshake (c, cflag, sat)
//   count               number of valid entries held in the pipeline
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             cflag,
    output logic             sat,
    output logic [CNT_W-1:0] count
);
    localparam int DW = WIDTH + 2;

    logic             sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_c;
    logic             res_cf;
    logic             res_sat;

    logic [STAGES-1:0] v;
    logic [DW-1:0]     d   [STAGES];
    logic [STAGES-1:0] vin;
    logic [DW-1:0]     din [STAGES];
    logic [STAGES-1:0] adv;

    // Subtract is a + ~b + 1; the top bit is then "no borrow".
    always_comb begin
        sub     = op[0];
        sum     = {1'b0, a} + {1'b0, (sub ? ~b : b)}
                + {{WIDTH{1'b0}}, sub};
        res_cf  = sub ? ~sum[WIDTH] : sum[WIDTH];
        res_c   = sum[WIDTH-1:0];
        res_sat = 1'b0;
        if (op[1] && res_cf) begin
            res_sat = 1'b1;
            res_c   = sub ? '0 : '1;
        end
    end

    // A stage may advance if it, or any stage below it, is empty,
    // or the consumer takes the output. Written as a suffix AND of
    // valid bits to avoid a self-referencing combinational chain.
    always_comb begin
        logic full_below;
        full_below = 1'b1;
        adv        = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full_below = full_below & v[i];
            adv[i]     = out_ready | ~full_below;
        end
    end

    always_comb begin
        vin[0] = in_valid;
        din[0] = {res_c, res_cf, res_sat};
        for (int i = 1; i < STAGES; i++) begin
            vin[i] = v[i-1];
            din[i] = d[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) d[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (adv[i]) begin
                    v[i] <= vin[i];
                    // Keep the last result when a bubble moves in.
                    if (vin[i]) d[i] <= din[i];
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < STAGES; i++) begin
            count = count + CNT_W'(v[i]);
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign c         = d[STAGES-1][DW-1:2];
    assign cflag     = d[STAGES-1][1];
    assign sat       = d[STAGES-1][0];

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the combinational A+B adder.
- Performs add/subtract in WIDTH bits, with optional unsigned saturation.
- Results pass through a STAGES-deep valid/ready pipeline with backpressure and bubble collapsing.
- Sits between a stimulus producer and a result consumer in the simulation/VPI test environment. Also reports carry/borrow and pipeline occupancy.

Parameters:
- WIDTH, 16, operand and result width in bits (≥2).
- STAGES, 2, pipeline depth in registers (≥1); latency with no backpressure equals STAGES cycles.
- CNT_W, $clog2(STAGES+1), width of the occupancy output.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  operation: 00 add, 01 sub, 10 add-sat, 11 sub-sat (unsigned).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- c  output  WIDTH  result.
- cflag  output  1  add: carry out; sub: borrow (a<b); identical semantics in sat modes.
- sat  output  1  result was clamped (sat modes only; 0 for op 00/01).
- count  output  CNT_W  number of valid entries currently held in the pipeline.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset (async, immediate): all stage valid bits = 0, so out_valid = 0 and count = 0.
  - c, cflag and sat = 0 during and after reset until the first result.
  - in_ready = 1 from the first cycle after rst deasserts. Only valid bits and outputs require reset.
- Reset mid-operation discards all in-flight beats; no partial result is emitted.
- Stage 0 computes on accept: a (WIDTH+1)-bit sum a+b, or a-b via a+~b+1.
  - Add: cflag = bit WIDTH.
  - Sub: cflag = borrow = ~bit WIDTH.
  - op 10 with carry: c = all ones, sat = 1.
  - op 11 with borrow: c = 0, sat = 1.
  - Otherwise c = low WIDTH bits, sat = 0. Results wrap modulo 2^WIDTH in op 00/01.
- Stages 1..STAGES-1 delay {c, cflag, sat} unchanged.
- Handshake per stage i: advance_i = ~v_i | advance_{i+1}, with advance_STAGES = out_ready.
  - in_ready = advance_0, combinationally derived from out_ready and the valid bits.
  - A beat transfers when valid & ready are both high in the same cycle.
- Bubble collapse: an empty stage accepts data even when downstream is stalled, so STAGES beats can be held while out_ready = 0.
- Stall: when out_valid=1 and out_ready=0, c/cflag/sat hold stable and out_valid stays 1 (no retraction).
- Full: all STAGES valid bits set and out_ready = 0 → in_ready = 0 and inputs are ignored.
- Full with out_ready = 1: accept and emit in the same cycle; count unchanged (simultaneous push/pop).
- Throughput: 1 beat/cycle sustained while out_ready = 1.
- count: +1 on input accept only, -1 on output accept only, unchanged on both or neither. Never exceeds STAGES.
- in_valid with in_ready = 0: no state change; the producer holds a, b and op.
- Ordering strictly FIFO; op is captured with its operands.

Test Plan:
- Reset, then a=16'h0003, b=16'h0004, op=00, in_valid for 1 cycle, out_ready=1 → out_valid exactly 2 cycles later; c=16'h0007, cflag=0, sat=0; count goes 1,1,0.
- op=00, a=16'hFFFF, b=16'h0002 → c=16'h0001, cflag=1, sat=0. Same operands with op=10 → c=16'hFFFF, cflag=1, sat=1.
- op=01, a=16'h0005, b=16'h0009 → c=16'hFFFC, cflag=1. Same operands with op=11 → c=16'h0000, sat=1. With a=16'h0009, b=16'h0005, op=11 → c=16'h0004, cflag=0, sat=0.
- Hold out_ready=0 and stream in_valid=1 with a=1..4, b=0 → exactly 2 beats accepted, then in_ready=0 and count=2, c stable at 1. Release out_ready → results 1,2,3,4 in order with no loss or duplication; in_ready rises the same cycle.
- Full pipeline with out_ready=1 and in_valid=1 continuously for 10 cycles → 1 result/cycle, count constant at STAGES, results match a reference model.
- Assert rst mid-stream with 2 beats in flight → out_valid and count drop to 0 immediately (asynchronously, before the next clk edge); after release, a fresh beat produces a correct result with no stale output.
